host_cmd_decoder: RTL and testbench
===================================

# host_cmd_decoder

Receives the PC-to-FPGA command stream from the UART receiver (`rx_data` / `rx_ready`) and turns framed host commands into single-cycle control pulses for the game core. It carries start requests, remote mole hits and link pings, which makes it the inbound counterpart of the mole-position bytes the FPGA transmits to the PC. It sits between `uart_rx` and the game FSM / hit-detection logic and is clocked by the 100 MHz system clock.

## Interface

**Parameters**
- `TIMEOUT_CLKS`, default 1_000_000: maximum idle gap between bytes inside a frame (10 ms at 100 MHz).
- `ERR_CNT_BITS`, default 8: width of the saturating error counter.

**Ports**
- `clock`, in, 1: system clock, 100 MHz. This is the block's only clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `rx_data`, in, 8: received byte. Valid only while `rx_ready` is high.
- `rx_ready`, in, 1: single-cycle strobe, one per received byte.
- `hit_enable`, in, 1: game active. HIT commands are accepted only while this is high.
- `cmd_start`, out, 1: one-cycle pulse when a valid START frame is received.
- `cmd_hit`, out, 1: one-cycle pulse when a valid HIT frame is received.
- `hit_mask`, out, 5: mole mask of the last accepted HIT. Held until the next accepted HIT.
- `cmd_ping`, out, 1: one-cycle pulse when a valid PING frame is received. The TX side uses it to echo an acknowledgement.
- `frame_error`, out, 1: one-cycle pulse when a frame is rejected.
- `err_code`, out, 3: cause of the last rejection. Held until the next error.
- `err_count`, out, `ERR_CNT_BITS`: count of rejected frames, saturating.

## Operation

**Frame format.** Every frame is 4 bytes, sent in this order:
1. `HDR` = 0xA5
2. `CMD`
3. `PAYLOAD`
4. `CHK` = 0xA5 ^ CMD ^ PAYLOAD

**Opcodes**
- START = 0x01: payload is ignored.
- HIT = 0x02: payload[4:0] is the mole mask; payload[7:5] must be 0.
- PING = 0x03: payload is ignored.

**FSM states**
- `IDLE`: wait for a header byte.
  - `rx_ready` with 0xA5 → `GET_CMD`.
  - Any other byte is discarded silently. No error is raised.
- `GET_CMD`: latch CMD on `rx_ready` → `GET_PAY`. A value of 0xA5 here is treated as CMD, not as a new header.
- `GET_PAY`: latch PAYLOAD on `rx_ready` → `GET_CHK`.
- `GET_CHK`: on `rx_ready`, evaluate the frame → `IDLE`. Checks are applied in this priority order:
  1. Checksum mismatch → `err_code` = 1 (BAD_CHK).
  2. Unknown opcode → `err_code` = 2 (BAD_OP).
  3. HIT with payload[7:5] ≠ 0, or payload[4:0] = 0 → `err_code` = 3 (BAD_PAY).
  4. HIT while `hit_enable` = 0 → `err_code` = 4 (NOT_ACTIVE).
  5. Otherwise, pulse the matching `cmd_*` output. For HIT, also load `hit_mask`.

**Inter-byte timeout**
- An idle counter is cleared on every `rx_ready` and increments every cycle while the FSM is not in `IDLE`.
- When the counter reaches `TIMEOUT_CLKS-1`, the FSM goes to `IDLE`, `frame_error` pulses and `err_code` = 5 (TIMEOUT).

**Error accounting**
- Every `frame_error` pulse increments `err_count`.
- `err_count` saturates at 2^`ERR_CNT_BITS`-1 and never wraps.

## Timing

- **Reset values:** all outputs are 0, the FSM is in `IDLE`, and the timeout counter is 0.
- **Reset mid-frame:** the partial frame is dropped. No error is flagged.
- **Output latency:** `cmd_start`, `cmd_hit`, `cmd_ping` and `frame_error` are registered. They are high exactly one cycle, on the cycle after the `rx_ready` that delivers CHK.
- **`hit_mask` and `err_code`:** both update on the same edge as their pulse.
- **Mutual exclusion:** at most one of `cmd_start`, `cmd_hit`, `cmd_ping` and `frame_error` is high in any cycle.
- **`rx_ready` on the timeout cycle:** the byte wins. It is consumed normally, the counter restarts, and no timeout is raised.
- **Back-to-back frames:** no dead cycle is required. A header arriving on the cycle after CHK is accepted.
- **`hit_enable`:** sampled on the CHK cycle only.
- **`rx_ready` assumptions:** `rx_ready` is assumed synchronous to `clock` and never high on two consecutive cycles. This is guaranteed by `uart_rx`.

## Structure

**Shared package `host_proto_pkg`** contains:
- the header constant 0xA5;
- the opcode constants START, HIT and PING;
- the `err_code` enumeration: 0 NONE, 1 BAD_CHK, 2 BAD_OP, 3 BAD_PAY, 4 NOT_ACTIVE, 5 TIMEOUT;
- the FSM state encoding.

The TX-side framer reuses the same package.

**Sub-module `rx_frame_timer`** is the parameterised inter-byte timeout counter. Its signals are:
- inputs `clock`, `reset`, `clear`, `run`;
- output `expired`, a single-cycle pulse.

The decoder FSM, the validation logic and the error counter live in `host_cmd_decoder`.

## Test plan

1. **Valid START:** feed A5 01 00 A4. `cmd_start` is high for exactly 1 cycle, one cycle after the 4th `rx_ready`. `err_count` stays 0.
2. **Valid HIT while active:** with `hit_enable`=1, feed A5 02 05 A2. `cmd_hit` pulses and `hit_mask`=5'b00101. Repeat with `hit_enable`=0: `frame_error` pulses, `err_code`=4 and `hit_mask` still reads 5'b00101.
3. **Bad checksum, then garbage:** feed A5 03 00 00. Expect `frame_error`, `err_code`=1 and `err_count`=1. Then feed 3C 7F followed by a valid PING (A5 03 00 A6). Only `cmd_ping` pulses and `err_count` stays 1.
4. **Timeout:** with `TIMEOUT_CLKS`=16, feed A5 02 then stop. `frame_error` pulses with `err_code`=5 exactly 16 cycles after the last `rx_ready`. A following valid START decodes normally.
5. **Bad opcode and payload:** feed A5 09 00 AC, which gives `err_code`=2. Then feed A5 02 25 82 (payload bit 5 set), which gives `err_code`=3. `err_count`=2.
6. **Saturation and reset:** with `ERR_CNT_BITS`=2, send 5 bad-checksum frames. `err_count` holds at 3. Assert `reset` low after A5 01. All outputs go to 0, and the next valid START decodes correctly.

Source files
------------

// File: rtl/host_proto_pkg.sv
// Host link protocol definitions shared by the RX decoder and the TX framer.
// Contents: frame header, opcodes, rejection codes, decoder FSM encoding,
// and the frame checksum helper.
package host_proto_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned MASK_W = 5;

  localparam logic [BYTE_W-1:0] HDR_BYTE = 8'hA5;

  localparam logic [BYTE_W-1:0] OP_START = 8'h01;
  localparam logic [BYTE_W-1:0] OP_HIT   = 8'h02;
  localparam logic [BYTE_W-1:0] OP_PING  = 8'h03;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_BAD_CHK    = 3'd1,
    ERR_BAD_OP     = 3'd2,
    ERR_BAD_PAY    = 3'd3,
    ERR_NOT_ACTIVE = 3'd4,
    ERR_TIMEOUT    = 3'd5
  } err_code_e;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] ST_GET_CMD = 2'd1;
  localparam logic [ST_W-1:0] ST_GET_PAY = 2'd2;
  localparam logic [ST_W-1:0] ST_GET_CHK = 2'd3;

  // Checksum byte expected at the end of a frame.
  function automatic logic [BYTE_W-1:0] calc_chk(input logic [BYTE_W-1:0] cmd,
                                                 input logic [BYTE_W-1:0] pay);
    return HDR_BYTE ^ cmd ^ pay;
  endfunction

endpackage

// File: rtl/rx_frame_timer.sv
// Inter-byte timeout counter for the host command decoder.
// Ports: clock, reset (async active-low), clear (restart count),
//        run (count while high), expired (one-cycle pulse on the cycle the
//        count sits at TIMEOUT_CLKS-1). TIMEOUT_CLKS must be >= 2.
module rx_frame_timer #(
  parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TIMEOUT_CLKS - 2);

  logic [CNT_W-1:0] r_cnt;
  logic             r_expired;

  // Pulse is registered one count early so it lines up with count == TIMEOUT_CLKS-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else if (clear || !run || r_expired) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
    end else begin
      r_cnt     <= r_cnt + CNT_W'(1);
      r_expired <= (r_cnt == PRE_LAST);
    end
  end

  assign expired = r_expired;

endmodule

// File: rtl/host_cmd_decoder.sv
// Decodes 4-byte host frames (HDR, CMD, PAYLOAD, CHK) from uart_rx into
// single-cycle command pulses for the game core.
// Ports: clock, reset (async active-low), rx_data/rx_ready (byte strobe),
//        hit_enable (game active); outputs cmd_start, cmd_hit, cmd_ping,
//        frame_error (pulses), hit_mask, err_code (held), err_count (saturating).
module host_cmd_decoder
  import host_proto_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 1_000_000,
  parameter int unsigned ERR_CNT_BITS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_ready,
  input  logic                    hit_enable,
  output logic                    cmd_start,
  output logic                    cmd_hit,
  output logic [4:0]              hit_mask,
  output logic                    cmd_ping,
  output logic                    frame_error,
  output logic [2:0]              err_code,
  output logic [ERR_CNT_BITS-1:0] err_count
);

  logic [ST_W-1:0]         r_state, w_state_nxt;
  logic [BYTE_W-1:0]       r_cmd, w_cmd_nxt;
  logic [BYTE_W-1:0]       r_pay, w_pay_nxt;
  logic                    r_start, w_start_nxt;
  logic                    r_hit, w_hit_nxt;
  logic                    r_ping, w_ping_nxt;
  logic                    r_ferr, w_ferr_nxt;
  logic [MASK_W-1:0]       r_mask, w_mask_nxt;
  err_code_e               r_err_code, w_err_code_nxt;
  logic [ERR_CNT_BITS-1:0] r_err_count, w_err_count_nxt;

  logic w_expired;
  logic w_chk_ok;
  logic w_op_known;
  logic w_pay_ok;
  logic w_is_hit;

  rx_frame_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (rx_ready),
    .run    (r_state != ST_IDLE),
    .expired(w_expired)
  );

  // Frame validation terms, only meaningful while CHK is on rx_data.
  assign w_chk_ok   = (rx_data == calc_chk(r_cmd, r_pay));
  assign w_op_known = (r_cmd == OP_START) || (r_cmd == OP_HIT) || (r_cmd == OP_PING);
  assign w_pay_ok   = (r_pay[7:5] == 3'b000) && (r_pay[4:0] != 5'd0);
  assign w_is_hit   = (r_cmd == OP_HIT);

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_nxt       = r_cmd;
    w_pay_nxt       = r_pay;
    w_start_nxt     = 1'b0;
    w_hit_nxt       = 1'b0;
    w_ping_nxt      = 1'b0;
    w_ferr_nxt      = 1'b0;
    w_mask_nxt      = r_mask;
    w_err_code_nxt  = r_err_code;
    w_err_count_nxt = r_err_count;

    case (r_state)
      ST_IDLE: begin
        if (rx_ready && (rx_data == HDR_BYTE)) w_state_nxt = ST_GET_CMD;
      end
      ST_GET_CMD: begin
        if (rx_ready) begin
          w_cmd_nxt   = rx_data;
          w_state_nxt = ST_GET_PAY;
        end
      end
      ST_GET_PAY: begin
        if (rx_ready) begin
          w_pay_nxt   = rx_data;
          w_state_nxt = ST_GET_CHK;
        end
      end
      ST_GET_CHK: begin
        if (rx_ready) begin
          w_state_nxt = ST_IDLE;
          if (!w_chk_ok) begin
            w_ferr_nxt     = 1'b1;
            w_err_code_nxt = ERR_BAD_CHK;
          end else if (!w_op_known) begin
            w_ferr_nxt     = 1'b1;
            w_err_code_nxt = ERR_BAD_OP;
          end else if (w_is_hit && !w_pay_ok) begin
            w_ferr_nxt     = 1'b1;
            w_err_code_nxt = ERR_BAD_PAY;
          end else if (w_is_hit && !hit_enable) begin
            w_ferr_nxt     = 1'b1;
            w_err_code_nxt = ERR_NOT_ACTIVE;
          end else if (w_is_hit) begin
            w_hit_nxt  = 1'b1;
            w_mask_nxt = r_pay[4:0];
          end else if (r_cmd == OP_START) begin
            w_start_nxt = 1'b1;
          end else begin
            w_ping_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // A byte arriving on the expiry cycle wins over the timeout.
    if (w_expired && !rx_ready && (r_state != ST_IDLE)) begin
      w_state_nxt    = ST_IDLE;
      w_ferr_nxt     = 1'b1;
      w_err_code_nxt = ERR_TIMEOUT;
    end

    if (w_ferr_nxt && (r_err_count != {ERR_CNT_BITS{1'b1}}))
      w_err_count_nxt = r_err_count + ERR_CNT_BITS'(1);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cmd       <= '0;
      r_pay       <= '0;
      r_start     <= 1'b0;
      r_hit       <= 1'b0;
      r_ping      <= 1'b0;
      r_ferr      <= 1'b0;
      r_mask      <= '0;
      r_err_code  <= ERR_NONE;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd       <= w_cmd_nxt;
      r_pay       <= w_pay_nxt;
      r_start     <= w_start_nxt;
      r_hit       <= w_hit_nxt;
      r_ping      <= w_ping_nxt;
      r_ferr      <= w_ferr_nxt;
      r_mask      <= w_mask_nxt;
      r_err_code  <= w_err_code_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  assign cmd_start   = r_start;
  assign cmd_hit     = r_hit;
  assign cmd_ping    = r_ping;
  assign frame_error = r_ferr;
  assign hit_mask    = r_mask;
  assign err_code    = r_err_code;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_host_cmd_decoder.sv
// Directed testbench for host_cmd_decoder (TIMEOUT_CLKS=16, ERR_CNT_BITS=2).
module tb_host_cmd_decoder;

  logic       clock;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       hit_enable;
  logic       cmd_start;
  logic       cmd_hit;
  logic [4:0] hit_mask;
  logic       cmd_ping;
  logic       frame_error;
  logic [2:0] err_code;
  logic [1:0] err_count;

  int errors = 0;
  int checks = 0;
  int ferr_seen = 0;

  host_cmd_decoder #(
    .TIMEOUT_CLKS(16),
    .ERR_CNT_BITS(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .hit_enable (hit_enable),
    .cmd_start  (cmd_start),
    .cmd_hit    (cmd_hit),
    .hit_mask   (hit_mask),
    .cmd_ping   (cmd_ping),
    .frame_error(frame_error),
    .err_code   (err_code),
    .err_count  (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count frame_error cycles and flag any overlap of pulses.
  always @(negedge clock) begin
    if (frame_error) ferr_seen++;
    if ((int'(cmd_start) + int'(cmd_hit) + int'(cmd_ping) + int'(frame_error)) > 1) begin
      $display("FAIL mutex: start=%0b hit=%0b ping=%0b ferr=%0b, want at most one high",
               cmd_start, cmd_hit, cmd_ping, frame_error);
      errors++;
    end
  end

  // Byte lands on the next rising edge; returns 1 ns after that edge.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clock); #1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] p, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(p);
    send_byte(k);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({cmd_start, cmd_hit, cmd_ping, frame_error, hit_mask, err_code, err_count} !== 13'd0) begin
      $display("FAIL reset_outputs: got %b, want all zero",
               {cmd_start, cmd_hit, cmd_ping, frame_error, hit_mask, err_code, err_count});
      errors++;
    end
  endtask

  task automatic test_start();
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    checks++;
    if (cmd_start !== 1'b0) begin
      $display("FAIL start_early: got %0b want 0", cmd_start); errors++;
    end
    send_byte(8'hA4);
    checks++;
    if (cmd_start !== 1'b1) begin
      $display("FAIL start_pulse: got %0b want 1", cmd_start); errors++;
    end
    checks++;
    if (err_count !== 2'd0) begin
      $display("FAIL start_errcnt: got %0d want 0", err_count); errors++;
    end
    @(posedge clock); #1;
    checks++;
    if (cmd_start !== 1'b0) begin
      $display("FAIL start_width: got %0b want 0", cmd_start); errors++;
    end
  endtask

  task automatic test_hit();
    do_reset();
    hit_enable = 1'b1;
    send_frame(8'h02, 8'h05, 8'hA2);
    checks++;
    if (cmd_hit !== 1'b1 || hit_mask !== 5'b00101) begin
      $display("FAIL hit_active: got hit=%0b mask=%b want 1 00101", cmd_hit, hit_mask); errors++;
    end
    hit_enable = 1'b0;
    send_frame(8'h02, 8'h05, 8'hA2);
    checks++;
    if (frame_error !== 1'b1 || err_code !== 3'd4 || cmd_hit !== 1'b0) begin
      $display("FAIL hit_inactive: got ferr=%0b code=%0d hit=%0b want 1 4 0",
               frame_error, err_code, cmd_hit); errors++;
    end
    checks++;
    if (hit_mask !== 5'b00101) begin
      $display("FAIL hit_mask_hold: got %b want 00101", hit_mask); errors++;
    end
    hit_enable = 1'b1;
  endtask

  task automatic test_bad_chk_garbage();
    int snap;
    do_reset();
    send_frame(8'h03, 8'h00, 8'h00);
    checks++;
    if (frame_error !== 1'b1 || err_code !== 3'd1 || err_count !== 2'd1) begin
      $display("FAIL bad_chk: got ferr=%0b code=%0d cnt=%0d want 1 1 1",
               frame_error, err_code, err_count); errors++;
    end
    @(posedge clock); #1;
    snap = ferr_seen;
    send_byte(8'h3C); send_byte(8'h7F);
    send_frame(8'h03, 8'h00, 8'hA6);
    checks++;
    if (cmd_ping !== 1'b1) begin
      $display("FAIL ping_after_garbage: got %0b want 1", cmd_ping); errors++;
    end
    checks++;
    if (err_count !== 2'd1 || ferr_seen !== snap) begin
      $display("FAIL garbage_silent: got cnt=%0d extra_errs=%0d want 1 0",
               err_count, ferr_seen - snap); errors++;
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    do_reset();
    send_byte(8'hA5); send_byte(8'h02);
    repeat (15) begin
      @(posedge clock); #1;
      if (frame_error) early++;
    end
    checks++;
    if (early != 0) begin
      $display("FAIL timeout_early: got %0d error cycles want 0", early); errors++;
    end
    @(posedge clock); #1;
    checks++;
    if (frame_error !== 1'b1 || err_code !== 3'd5 || err_count !== 2'd1) begin
      $display("FAIL timeout_fire: got ferr=%0b code=%0d cnt=%0d want 1 5 1",
               frame_error, err_code, err_count); errors++;
    end
    send_frame(8'h01, 8'h00, 8'hA4);
    checks++;
    if (cmd_start !== 1'b1) begin
      $display("FAIL start_after_timeout: got %0b want 1", cmd_start); errors++;
    end
  endtask

  task automatic test_byte_wins();
    int snap;
    do_reset();
    snap = ferr_seen;
    send_byte(8'hA5);
    repeat (14) @(posedge clock);
    send_byte(8'h01);   // lands on the 16th edge after the header
    send_byte(8'h00);
    send_byte(8'hA4);
    checks++;
    if (cmd_start !== 1'b1 || ferr_seen !== snap || err_count !== 2'd0) begin
      $display("FAIL byte_wins: got start=%0b errs=%0d cnt=%0d want 1 0 0",
               cmd_start, ferr_seen - snap, err_count); errors++;
    end
  endtask

  task automatic test_bad_op_pay();
    do_reset();
    hit_enable = 1'b1;
    send_frame(8'h09, 8'h00, 8'hAC);
    checks++;
    if (frame_error !== 1'b1 || err_code !== 3'd2) begin
      $display("FAIL bad_op: got ferr=%0b code=%0d want 1 2", frame_error, err_code); errors++;
    end
    send_frame(8'h02, 8'h25, 8'h82);
    checks++;
    if (frame_error !== 1'b1 || err_code !== 3'd3 || err_count !== 2'd2) begin
      $display("FAIL bad_pay_hi: got ferr=%0b code=%0d cnt=%0d want 1 3 2",
               frame_error, err_code, err_count); errors++;
    end
    send_frame(8'h02, 8'h00, 8'hA7);
    checks++;
    if (frame_error !== 1'b1 || err_code !== 3'd3 || err_count !== 2'd3 || hit_mask !== 5'd0) begin
      $display("FAIL bad_pay_zero: got ferr=%0b code=%0d cnt=%0d mask=%b want 1 3 3 00000",
               frame_error, err_code, err_count, hit_mask); errors++;
    end
  endtask

  task automatic test_saturation_reset();
    int snap;
    do_reset();
    repeat (5) send_frame(8'h01, 8'h00, 8'h00);
    checks++;
    if (err_count !== 2'd3 || err_code !== 3'd1) begin
      $display("FAIL saturate: got cnt=%0d code=%0d want 3 1", err_count, err_code); errors++;
    end
    send_byte(8'hA5); send_byte(8'h01);
    reset = 1'b0;
    #1;
    checks++;
    if ({cmd_start, cmd_hit, cmd_ping, frame_error, hit_mask, err_code, err_count} !== 13'd0) begin
      $display("FAIL midframe_reset: got %b want all zero",
               {cmd_start, cmd_hit, cmd_ping, frame_error, hit_mask, err_code, err_count});
      errors++;
    end
    @(posedge clock); #1 reset = 1'b1;
    snap = ferr_seen;
    send_frame(8'h01, 8'h00, 8'hA4);
    checks++;
    if (cmd_start !== 1'b1 || err_count !== 2'd0 || ferr_seen !== snap) begin
      $display("FAIL start_after_reset: got start=%0b cnt=%0d errs=%0d want 1 0 0",
               cmd_start, err_count, ferr_seen - snap); errors++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    hit_enable = 1'b1;
    send_frame(8'h01, 8'h00, 8'hA4);
    checks++;
    if (cmd_start !== 1'b1) begin
      $display("FAIL b2b_start: got %0b want 1", cmd_start); errors++;
    end
    send_frame(8'h02, 8'h11, 8'hB6);
    checks++;
    if (cmd_hit !== 1'b1 || hit_mask !== 5'b10001) begin
      $display("FAIL b2b_hit: got hit=%0b mask=%b want 1 10001", cmd_hit, hit_mask); errors++;
    end
    send_frame(8'h03, 8'h7E, 8'hD8);
    checks++;
    if (cmd_ping !== 1'b1 || hit_mask !== 5'b10001) begin
      $display("FAIL b2b_ping: got ping=%0b mask=%b want 1 10001", cmd_ping, hit_mask); errors++;
    end
  endtask

  initial begin
    reset      = 1'b0;
    rx_data    = 8'h00;
    rx_ready   = 1'b0;
    hit_enable = 1'b1;
    test_reset();
    test_start();
    test_hit();
    test_bad_chk_garbage();
    test_timeout();
    test_byte_wins();
    test_bad_op_pay();
    test_saturation_reset();
    test_back_to_back();
    repeat (3) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
